// File: rtl/vga_tmds_encoder.sv
// rtl/vga_tmds_encoder.sv - three-channel DVI TMDS encoder for 4-bit VGA RGB; colour bars with VGA_TMDS_TESTPAT_EN
module vga_tmds_encoder #(
    parameter int BAR_SHIFT = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] vga_red_i,
    input  logic [3:0] vga_green_i,
    input  logic [3:0] vga_blue_i,
    input  logic       horiz_sync,
    input  logic       vert_sync,
    input  logic       vga_de_i,
    input  logic       test_pat,
    output logic [9:0] tmds_red,
    output logic [9:0] tmds_green,
    output logic [9:0] tmds_blue
);

    localparam logic [9:0] TOK_00 = 10'b1101010100;
    localparam logic [9:0] TOK_01 = 10'b0010101011;
    localparam logic [9:0] TOK_10 = 10'b0101010100;
    localparam logic [9:0] TOK_11 = 10'b1010101011;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    function automatic logic [8:0] stage1_qm(input logic [7:0] d);
        logic [8:0] q;
        logic [3:0] n1d;
        logic       use_xnor;
        n1d      = ones8(d);
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = ~use_xnor;
        return q;
    endfunction

    // Returns {next disparity, symbol}. diff = N1-N0 = 2*N1-8; the 5-bit wrap keeps N1=8 -> +8 exact.
    function automatic logic [14:0] stage2_sym(input logic [8:0] qm, input logic signed [4:0] cnt);
        logic [3:0]        n1;
        logic signed [4:0] diff;
        logic signed [4:0] nxt;
        logic [9:0]        sym;
        n1   = ones8(qm[7:0]);
        diff = $signed({n1, 1'b0}) - 5'sd8;
        if ((cnt == 5'sd0) || (diff == 5'sd0)) begin
            sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            nxt = qm[8] ? (cnt + diff) : (cnt - diff);
        end else if (cnt[4] == diff[4]) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            nxt = cnt - diff + (qm[8] ? 5'sd2 : 5'sd0);
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            nxt = cnt + diff - (qm[8] ? 5'sd0 : 5'sd2);
        end
        return {nxt, sym};
    endfunction

    logic [3:0] src_red, src_green, src_blue;

`ifdef VGA_TMDS_TESTPAT_EN
    logic [9:0] px;
    logic [2:0] bar;

    assign bar       = px[BAR_SHIFT+2:BAR_SHIFT];
    assign src_red   = test_pat ? {4{bar[2]}} : vga_red_i;
    assign src_green = test_pat ? {4{bar[1]}} : vga_green_i;
    assign src_blue  = test_pat ? {4{bar[0]}} : vga_blue_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        px <= '0;
        else if (vga_de_i) px <= px + 10'd1;
        else               px <= '0;
    end
`else
    logic unused_cfg;

    assign unused_cfg = test_pat & (BAR_SHIFT > 0);
    assign src_red    = vga_red_i;
    assign src_green  = vga_green_i;
    assign src_blue   = vga_blue_i;
`endif

    logic [7:0]        d_red, d_green, d_blue;
    logic              de0, hs0, vs0;
    logic [8:0]        qm_red, qm_green, qm_blue;
    logic              de1, hs1, vs1;
    logic signed [4:0] cnt_red, cnt_green, cnt_blue;
    logic [14:0]       enc_red, enc_green, enc_blue;
    logic [9:0]        blue_tok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_red   <= '0;
            d_green <= '0;
            d_blue  <= '0;
            de0     <= 1'b0;
            hs0     <= 1'b0;
            vs0     <= 1'b0;
        end else begin
            d_red   <= {src_red, src_red};
            d_green <= {src_green, src_green};
            d_blue  <= {src_blue, src_blue};
            de0     <= vga_de_i;
            hs0     <= horiz_sync;
            vs0     <= vert_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qm_red   <= '0;
            qm_green <= '0;
            qm_blue  <= '0;
            de1      <= 1'b0;
            hs1      <= 1'b0;
            vs1      <= 1'b0;
        end else begin
            qm_red   <= stage1_qm(d_red);
            qm_green <= stage1_qm(d_green);
            qm_blue  <= stage1_qm(d_blue);
            de1      <= de0;
            hs1      <= hs0;
            vs1      <= vs0;
        end
    end

    assign enc_red   = stage2_sym(qm_red, cnt_red);
    assign enc_green = stage2_sym(qm_green, cnt_green);
    assign enc_blue  = stage2_sym(qm_blue, cnt_blue);

    always_comb begin
        blue_tok = TOK_00;
        case ({vs1, hs1})
            2'b00:   blue_tok = TOK_00;
            2'b01:   blue_tok = TOK_01;
            2'b10:   blue_tok = TOK_10;
            default: blue_tok = TOK_11;
        endcase
    end

    // Blanking zeroes disparity so every active run starts balanced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmds_red   <= TOK_00;
            tmds_green <= TOK_00;
            tmds_blue  <= TOK_00;
            cnt_red    <= '0;
            cnt_green  <= '0;
            cnt_blue   <= '0;
        end else if (de1) begin
            tmds_red   <= enc_red[9:0];
            tmds_green <= enc_green[9:0];
            tmds_blue  <= enc_blue[9:0];
            cnt_red    <= $signed(enc_red[14:10]);
            cnt_green  <= $signed(enc_green[14:10]);
            cnt_blue   <= $signed(enc_blue[14:10]);
        end else begin
            tmds_red   <= TOK_00;
            tmds_green <= TOK_00;
            tmds_blue  <= blue_tok;
            cnt_red    <= '0;
            cnt_green  <= '0;
            cnt_blue   <= '0;
        end
    end

endmodule

// File: tb/tb_vga_tmds_encoder.sv
// tb/tb_vga_tmds_encoder.sv - randomized bench for vga_tmds_encoder against a TMDS reference model
module tb_vga_tmds_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] vga_red_i = '0, vga_green_i = '0, vga_blue_i = '0;
    logic       horiz_sync = 1'b0, vert_sync = 1'b0, vga_de_i = 1'b0, test_pat = 1'b0;
    logic [9:0] tmds_red, tmds_green, tmds_blue;

    vga_tmds_encoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vga_red_i   (vga_red_i),
        .vga_green_i (vga_green_i),
        .vga_blue_i  (vga_blue_i),
        .horiz_sync  (horiz_sync),
        .vert_sync   (vert_sync),
        .vga_de_i    (vga_de_i),
        .test_pat    (test_pat),
        .tmds_red    (tmds_red),
        .tmds_green  (tmds_green),
        .tmds_blue   (tmds_blue)
    );

    always #20 clk = ~clk;

    typedef struct packed {
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
        logic       de;
        logic [7:0] dr;
        logic [7:0] dg;
        logic [7:0] db;
    } exp_t;

    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t q[$];
    exp_t cur;
    logic have_out;
    int   mcnt[3];
    int   mpx;

    function automatic int ones(input logic [7:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) if (v[i]) n++;
        return n;
    endfunction

    function automatic logic [9:0] token(input logic c1, input logic c0);
        case ({c1, c0})
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] qv, d;
        qv = s[9] ? ~s[7:0] : s[7:0];
        d[0] = qv[0];
        for (int i = 1; i < 8; i++) d[i] = s[8] ? (qv[i] ^ qv[i-1]) : ~(qv[i] ^ qv[i-1]);
        return d;
    endfunction

    task automatic ref_chan(input int ch, input logic [7:0] d, output logic [9:0] sym);
        int n1d, n1, n0;
        logic use_xnor;
        logic [8:0] qm;
        n1d = ones(d);
        use_xnor = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !use_xnor;
        n1 = ones(qm[7:0]);
        n0 = 8 - n1;
        if (mcnt[ch] == 0 || n1 == n0) begin
            sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            mcnt[ch] += qm[8] ? (n1 - n0) : (n0 - n1);
        end else if ((mcnt[ch] > 0 && n1 > n0) || (mcnt[ch] < 0 && n0 > n1)) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            mcnt[ch] += (qm[8] ? 2 : 0) + n0 - n1;
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            mcnt[ch] += (qm[8] ? 0 : -2) + n1 - n0;
        end
    endtask

    task automatic reset_model;
        exp_t e;
        q.delete();
        mcnt = '{0, 0, 0};
        mpx = 0;
        e = '0;
        e.r = 10'h354; e.g = 10'h354; e.b = 10'h354;
        q.push_back(e);
        q.push_back(e);
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                        input logic hs, input logic vs, input logic de, input logic tp);
        exp_t e;
        logic [3:0] cr, cg, cb;
        logic [9:0] sr, sg, sb;
        vga_red_i = r; vga_green_i = g; vga_blue_i = b;
        horiz_sync = hs; vert_sync = vs; vga_de_i = de; test_pat = tp;
        cr = r; cg = g; cb = b;
`ifdef VGA_TMDS_TESTPAT_EN
        begin
            logic [2:0] bar;
            bar = 3'((mpx / 64) % 8);
            if (tp) begin
                cr = bar[2] ? 4'hF : 4'h0;
                cg = bar[1] ? 4'hF : 4'h0;
                cb = bar[0] ? 4'hF : 4'h0;
            end
            mpx = de ? mpx + 1 : 0;
        end
`endif
        e = '0;
        e.de = de;
        e.dr = {cr, cr}; e.dg = {cg, cg}; e.db = {cb, cb};
        if (de) begin
            ref_chan(0, e.dr, sr);
            ref_chan(1, e.dg, sg);
            ref_chan(2, e.db, sb);
        end else begin
            sr = 10'h354; sg = 10'h354; sb = token(vs, hs);
            mcnt = '{0, 0, 0};
        end
        e.r = sr; e.g = sg; e.b = sb;
        q.push_back(e);
        @(posedge clk);
        #1;
        have_out = 1'b0;
        if (q.size() >= 3) begin
            cur = q.pop_front();
            have_out = 1'b1;
        end
    endtask

    task automatic test_reset;
        @(posedge clk);
        #1;
        vga_de_i = 1'b1; vga_red_i = 4'h9; vga_green_i = 4'h3; vga_blue_i = 4'hC;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({tmds_red, tmds_green, tmds_blue} !== {3{10'h354}}) begin
            n_fail++;
            $display("FAIL reset_async: got %h %h %h want 354 each", tmds_red, tmds_green, tmds_blue);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (tmds_red !== 10'h354) begin n_fail++; $display("FAIL reset_red: got %h want 354", tmds_red); end
            n_cmp++;
            if (tmds_green !== 10'h354) begin n_fail++; $display("FAIL reset_green: got %h want 354", tmds_green); end
            n_cmp++;
            if (tmds_blue !== 10'h354) begin n_fail++; $display("FAIL reset_blue: got %h want 354", tmds_blue); end
        end
        vga_de_i = 1'b0; vga_red_i = '0; vga_green_i = '0; vga_blue_i = '0;
        rst_n = 1'b1;
        reset_model();
        for (int c = 0; c < 5; c++) begin
            step(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (have_out) begin
                n_cmp++;
                if ({tmds_red, tmds_green, tmds_blue} !== {cur.r, cur.g, cur.b}) begin
                    n_fail++;
                    $display("FAIL post_reset: got %h %h %h want %h %h %h", tmds_red, tmds_green, tmds_blue, cur.r, cur.g, cur.b);
                end
            end
        end
    endtask

    task automatic test_sync;
        for (int c = 0; c < 12; c++) begin
            step(4'($urandom), 4'($urandom), 4'($urandom), 1'b1, (c >= 6), 1'b0, 1'b0);
            if (have_out) begin
                n_cmp++;
                if ({tmds_red, tmds_green, tmds_blue} !== {cur.r, cur.g, cur.b}) begin
                    n_fail++;
                    $display("FAIL sync_model: got %h %h %h want %h %h %h", tmds_red, tmds_green, tmds_blue, cur.r, cur.g, cur.b);
                end
            end
            if (c == 5) begin
                n_cmp++;
                if ({tmds_red, tmds_green, tmds_blue} !== {10'h354, 10'h354, 10'h0AB}) begin
                    n_fail++;
                    $display("FAIL sync_hs: got %h %h %h want 354 354 0ab", tmds_red, tmds_green, tmds_blue);
                end
            end
            if (c == 11) begin
                n_cmp++;
                if (tmds_blue !== 10'h2AB) begin
                    n_fail++;
                    $display("FAIL sync_hs_vs: got %h want 2ab", tmds_blue);
                end
            end
        end
    endtask

    task automatic test_red_zero;
        int k;
        k = -1;
        for (int c = 0; c < 16; c++) begin
            step(4'h0, 4'($urandom), 4'($urandom), 1'b0, 1'b0, (c >= 3 && c < 11), 1'b0);
            if (have_out) begin
                n_cmp++;
                if ({tmds_red, tmds_green, tmds_blue} !== {cur.r, cur.g, cur.b}) begin
                    n_fail++;
                    $display("FAIL red_zero_model: got %h %h %h want %h %h %h", tmds_red, tmds_green, tmds_blue, cur.r, cur.g, cur.b);
                end
                k = cur.de ? k + 1 : -1;
                if (k == 0) begin
                    n_cmp++;
                    if (tmds_red !== 10'h100) begin n_fail++; $display("FAIL red_zero_first: got %h want 100", tmds_red); end
                end
                if (k == 1) begin
                    n_cmp++;
                    if (tmds_red !== 10'h3FF) begin n_fail++; $display("FAIL red_zero_second: got %h want 3ff", tmds_red); end
                end
            end
        end
    endtask

    task automatic test_green_full;
        int k;
        k = -1;
        for (int c = 0; c < 14; c++) begin
            step(4'($urandom), 4'hF, 4'($urandom), 1'b0, 1'b0, (c >= 3 && c < 9), 1'b0);
            if (have_out) begin
                n_cmp++;
                if ({tmds_red, tmds_green, tmds_blue} !== {cur.r, cur.g, cur.b}) begin
                    n_fail++;
                    $display("FAIL green_full_model: got %h %h %h want %h %h %h", tmds_red, tmds_green, tmds_blue, cur.r, cur.g, cur.b);
                end
                k = cur.de ? k + 1 : -1;
                if (k == 0) begin
                    n_cmp++;
                    if (tmds_green !== 10'h200) begin n_fail++; $display("FAIL green_full_first: got %h want 200", tmds_green); end
                end
            end
        end
    endtask

    task automatic test_random_lines;
        logic vs;
        for (int line = 0; line < 3; line++) begin
            vs = 1'($urandom);
            for (int x = 0; x < 800; x++) begin
                step(4'($urandom), 4'($urandom), 4'($urandom), (x >= 656 && x < 752), vs, (x < 640), 1'b0);
                if (have_out) begin
                    n_cmp++;
                    if (tmds_red !== cur.r) begin n_fail++; $display("FAIL line_red: got %h want %h", tmds_red, cur.r); end
                    n_cmp++;
                    if (tmds_green !== cur.g) begin n_fail++; $display("FAIL line_green: got %h want %h", tmds_green, cur.g); end
                    n_cmp++;
                    if (tmds_blue !== cur.b) begin n_fail++; $display("FAIL line_blue: got %h want %h", tmds_blue, cur.b); end
                    if (cur.de) begin
                        n_cmp++;
                        if ({decode(tmds_red), decode(tmds_green), decode(tmds_blue)} !== {cur.dr, cur.dg, cur.db}) begin
                            n_fail++;
                            $display("FAIL line_decode: got %h %h %h want %h %h %h", decode(tmds_red), decode(tmds_green), decode(tmds_blue), cur.dr, cur.dg, cur.db);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_de_toggle;
        int   len;
        logic de;
        de = 1'b0;
        for (int run = 0; run < 60; run++) begin
            len = $urandom_range(1, 12);
            de = ~de;
            for (int c = 0; c < len; c++) begin
                step(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), de, 1'b0);
                if (have_out) begin
                    n_cmp++;
                    if ({tmds_red, tmds_green, tmds_blue} !== {cur.r, cur.g, cur.b}) begin
                        n_fail++;
                        $display("FAIL de_toggle: got %h %h %h want %h %h %h", tmds_red, tmds_green, tmds_blue, cur.r, cur.g, cur.b);
                    end
                end
            end
        end
    endtask

`ifdef VGA_TMDS_TESTPAT_EN
    task automatic test_testpat;
        int         idx;
        int         plan[7];
        logic [2:0] bar;
        logic [7:0] wr, wg, wb;
        plan = '{4, 640, 4, 100, 3, 50, 6};
        idx = 0;
        for (int p = 0; p < 7; p++) begin
            for (int c = 0; c < plan[p]; c++) begin
                step(4'($urandom), 4'($urandom), 4'($urandom), 1'b0, 1'b0, (p % 2 == 1), 1'b1);
                if (have_out) begin
                    n_cmp++;
                    if ({tmds_red, tmds_green, tmds_blue} !== {cur.r, cur.g, cur.b}) begin
                        n_fail++;
                        $display("FAIL testpat_model: got %h %h %h want %h %h %h", tmds_red, tmds_green, tmds_blue, cur.r, cur.g, cur.b);
                    end
                    if (cur.de) begin
                        bar = 3'((idx / 64) % 8);
                        wr = bar[2] ? 8'hFF : 8'h00;
                        wg = bar[1] ? 8'hFF : 8'h00;
                        wb = bar[0] ? 8'hFF : 8'h00;
                        n_cmp++;
                        if ({decode(tmds_red), decode(tmds_green), decode(tmds_blue)} !== {wr, wg, wb}) begin
                            n_fail++;
                            $display("FAIL testpat_bar px %0d: got %h %h %h want %h %h %h", idx, decode(tmds_red), decode(tmds_green), decode(tmds_blue), wr, wg, wb);
                        end
                        idx++;
                    end else begin
                        idx = 0;
                    end
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sync();
        test_red_zero();
        test_green_full();
        test_random_lines();
        test_de_toggle();
`ifdef VGA_TMDS_TESTPAT_EN
        test_testpat();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
